// File: rtl/colorloop_sched_pkg.sv
// Shared types for the colorloop triangle scheduler: geometry/colour structs,
// the queued command record, FSM states and default parameter values.
package colorloop_sched_pkg;

   localparam int WIDTH  = 320;
   localparam int HEIGHT = 240;

   localparam int      DEF_DEPTH          = 4;
   localparam int      DEF_NUM_BANDS      = 1;
   localparam shortint DEF_BAND_STEP      = 16'sd4;
   localparam int      DEF_GAP_CYCLES     = 2;
   localparam int      DEF_TIMEOUT_CYCLES = 1048576;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [15:0] z;
   } Vertex3D;

   typedef struct packed {
      Vertex3D p;
      Vertex3D q;
      Vertex3D r;
   } Triangle3D;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } Color;

   // 'tri' is a reserved net keyword, hence tri3d.
   typedef struct packed {
      Triangle3D tri3d;
      Color      rgb;
   } TriCmd;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} SchedState;

endpackage

// File: rtl/colorloop_sched_fifo.sv
// Command FIFO for the scheduler: registered count and pointers, head entry
// visible combinationally, push when full is dropped.
module tri_cmd_fifo
   import colorloop_sched_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     i_push,
   input  TriCmd                    i_data,
   input  logic                     i_pop,
   output TriCmd                    o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   TriCmd         r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_push, w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/colorloop_sched.sv
// Triangle scheduler in front of colorloop: queues commands, runs NUM_BANDS
// passes per triangle, reports frame completion on flush. Optional
// SCHED_TIMEOUT_EN adds a RUN watchdog and sticky timeout output.
module colorloop_sched
   import colorloop_sched_pkg::*;
#(
   parameter int      DEPTH      = DEF_DEPTH,
   parameter int      NUM_BANDS  = DEF_NUM_BANDS,
   parameter shortint BAND_STEP  = DEF_BAND_STEP,
   parameter int      GAP_CYCLES = DEF_GAP_CYCLES
`ifdef SCHED_TIMEOUT_EN
   , parameter int    TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               tri_valid,
   input  Triangle3D          tri_in,
   input  Color               rgb_in,
   output logic               tri_ready,
   input  logic               flush_req,
   input  logic               cl_done,
   output logic               cl_color_en,
   output Triangle3D          cl_ver,
   output Color               cl_rgb,
   output logic signed [15:0] cl_height,
   output logic               busy,
   output logic               frame_done,
`ifdef SCHED_TIMEOUT_EN
   output logic               timeout,
`endif
   output logic [15:0]        tri_count
);

   SchedState          r_state, w_state_nxt;
   Triangle3D          r_ver;
   Color               r_rgb;
   logic signed [15:0] r_height;
   logic [15:0]        r_band, r_gap, r_tri_count;
   logic               r_done_q, r_flush_pend;
   logic               w_pop, w_full, w_empty, w_rise, w_gap_done, w_more, w_to, w_frame_done;
   logic [$clog2(DEPTH):0] w_count;
   TriCmd              w_head, w_push_cmd;

   assign w_push_cmd = '{tri3d: tri_in, rgb: rgb_in};

   tri_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .n_rst(n_rst),
      .i_push(tri_valid), .i_data(w_push_cmd), .i_pop(w_pop),
      .o_data(w_head), .o_full(w_full), .o_empty(w_empty), .o_count(w_count)
   );

   assign w_rise       = cl_done & ~r_done_q;
   assign w_gap_done   = (r_gap == '0);
   assign w_more       = (int'(r_band) + 1) < NUM_BANDS;
   assign w_frame_done = r_flush_pend & (r_state == IDLE) & w_empty;

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = LOAD;
         end
         LOAD: w_state_nxt = RUN;
         RUN: begin
            if (w_rise)    w_state_nxt = GAP;
            else if (w_to) w_state_nxt = IDLE;
         end
         GAP: if (w_gap_done) w_state_nxt = w_more ? RUN : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state      <= IDLE;
         r_ver        <= '0;
         r_rgb        <= '0;
         r_height     <= '0;
         r_band       <= '0;
         r_gap        <= '0;
         r_tri_count  <= '0;
         r_done_q     <= 1'b0;
         r_flush_pend <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_done_q     <= cl_done;
         r_flush_pend <= (r_flush_pend | flush_req) & ~w_frame_done;
         if (w_pop) begin
            r_ver    <= w_head.tri3d;
            r_rgb    <= w_head.rgb;
            r_band   <= '0;
            r_height <= '0;
         end
         if (r_state == RUN && w_rise) r_gap <= 16'(GAP_CYCLES - 1);
         // Band advance happens only as GAP expires, so outputs hold across RUN.
         if (r_state == GAP) begin
            if (!w_gap_done) begin
               r_gap <= r_gap - 16'd1;
            end else if (w_more) begin
               r_band   <= r_band + 16'd1;
               r_height <= r_height + BAND_STEP;
            end else begin
               r_tri_count <= r_tri_count + 16'd1;
            end
         end
      end
   end

`ifdef SCHED_TIMEOUT_EN
   logic [20:0] r_wdog;
   logic        r_timeout;

   assign w_to    = (r_state == RUN) & ~w_rise & (r_wdog == 21'(TIMEOUT_CYCLES - 1));
   assign timeout = r_timeout;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == RUN && !w_rise && !w_to) r_wdog <= r_wdog + 21'd1;
         else                                    r_wdog <= '0;
         if (w_to) r_timeout <= 1'b1;
      end
   end
`else
   assign w_to = 1'b0;
`endif

   assign tri_ready   = ~w_full;
   assign cl_color_en = (r_state == RUN);
   assign cl_ver      = r_ver;
   assign cl_rgb      = r_rgb;
   assign cl_height   = r_height;
   assign busy        = (r_state != IDLE) | (w_count != '0);
   assign frame_done  = w_frame_done;
   assign tri_count   = r_tri_count;

endmodule

// File: tb/tb_colorloop_sched.sv
// Directed bench for colorloop_sched: one DUT with defaults (1 band), one with
// 3 bands; each has a small colorloop model raising done after a fixed latency.
module tb_colorloop_sched;
   import colorloop_sched_pkg::*;

   localparam int LAT  = 50;
   localparam int LAT3 = 10;

   logic clk = 1'b0, n_rst = 1'b0;
   always #5 clk = ~clk;

   int total = 0, bad = 0;

   logic               tri_valid = 1'b0, flush_req = 1'b0;
   Triangle3D          tri_in = '0;
   Color               rgb_in = '0;
   logic               tri_ready, cl_done, cl_color_en, busy, frame_done;
   Triangle3D          cl_ver;
   Color               cl_rgb;
   logic signed [15:0] cl_height;
   logic [15:0]        tri_count;

   logic               tri_valid3 = 1'b0, flush3 = 1'b0;
   logic               ready3, cl_done3, en3, busy3, fd3;
   Triangle3D          ver3;
   Color               rgb3;
   logic signed [15:0] height3;
   logic [15:0]        cnt3;
`ifdef SCHED_TIMEOUT_EN
   logic timeout, timeout3;
`endif

   logic m_en = 1'b1, ovr = 1'b0, ovr_val = 1'b0, m_done = 1'b0, m_done3 = 1'b0;
   int   m_cnt = 0, m_cnt3 = 0;

   always @(posedge clk) begin
      if (!m_en || !cl_color_en) begin
         m_cnt <= 0; m_done <= 1'b0;
      end else begin
         m_cnt <= m_cnt + 1;
         if (m_cnt == LAT - 1) m_done <= 1'b1;
      end
   end
   assign cl_done = ovr ? ovr_val : m_done;

   always @(posedge clk) begin
      if (!en3) begin
         m_cnt3 <= 0; m_done3 <= 1'b0;
      end else begin
         m_cnt3 <= m_cnt3 + 1;
         if (m_cnt3 == LAT3 - 1) m_done3 <= 1'b1;
      end
   end
   assign cl_done3 = m_done3;

   colorloop_sched #(.DEPTH(4), .NUM_BANDS(1), .BAND_STEP(16'sd4), .GAP_CYCLES(2)
`ifdef SCHED_TIMEOUT_EN
      , .TIMEOUT_CYCLES(100)
`endif
   ) dut (
      .clk(clk), .n_rst(n_rst), .tri_valid(tri_valid), .tri_in(tri_in), .rgb_in(rgb_in),
      .tri_ready(tri_ready), .flush_req(flush_req), .cl_done(cl_done),
      .cl_color_en(cl_color_en), .cl_ver(cl_ver), .cl_rgb(cl_rgb), .cl_height(cl_height),
      .busy(busy), .frame_done(frame_done),
`ifdef SCHED_TIMEOUT_EN
      .timeout(timeout),
`endif
      .tri_count(tri_count)
   );

   colorloop_sched #(.DEPTH(4), .NUM_BANDS(3), .BAND_STEP(16'sd4), .GAP_CYCLES(2)) dut3 (
      .clk(clk), .n_rst(n_rst), .tri_valid(tri_valid3), .tri_in(tri_in), .rgb_in(rgb_in),
      .tri_ready(ready3), .flush_req(flush3), .cl_done(cl_done3),
      .cl_color_en(en3), .cl_ver(ver3), .cl_rgb(rgb3), .cl_height(height3),
      .busy(busy3), .frame_done(fd3),
`ifdef SCHED_TIMEOUT_EN
      .timeout(timeout3),
`endif
      .tri_count(cnt3)
   );

   function automatic Triangle3D mk(input int id);
      Triangle3D t;
      t.p.x = 16'sd0;           t.p.y = 16'sd0;            t.p.z = 16'(100 + id);
      t.q.x = 16'sd0;           t.q.y = 16'(HEIGHT - 1);   t.q.z = 16'(100 + id);
      t.r.x = 16'(WIDTH - 1);   t.r.y = 16'(HEIGHT - 1);   t.r.z = 16'(100 + id);
      return t;
   endfunction

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      tick; tick;
      total++; if (tri_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", tri_ready); end
      total++; if (cl_color_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
         bad++; $display("FAIL reset_ctl got en=%b busy=%b fd=%b exp=0", cl_color_en, busy, frame_done); end
      total++; if (tri_count !== 16'd0 || cl_height !== 16'sd0 || cl_ver !== '0) begin
         bad++; $display("FAIL reset_data got cnt=%0d h=%0d ver=%h exp=0", tri_count, cl_height, cl_ver); end
      n_rst = 1'b1;
      tick;
      total++; if (tri_ready !== 1'b1 || busy !== 1'b0 || ready3 !== 1'b1) begin
         bad++; $display("FAIL reset_release got rdy=%b busy=%b rdy3=%b", tri_ready, busy, ready3); end
   endtask

   task automatic test_single;
      int n, bv;
      Color c;
      c = '{8'd255, 8'd25, 8'd12};
      tri_in = mk(0); rgb_in = c; tri_valid = 1'b1;
      tick; tri_valid = 1'b0;
      total++; if (cl_color_en !== 1'b0) begin bad++; $display("FAIL single_c1_en got=%b exp=0", cl_color_en); end
      tick;
      total++; if (cl_color_en !== 1'b0 || cl_ver !== mk(0)) begin
         bad++; $display("FAIL single_load got en=%b ver=%h exp en=0 ver=%h", cl_color_en, cl_ver, mk(0)); end
      tick;
      total++; if (cl_color_en !== 1'b1) begin bad++; $display("FAIL single_latency got=%b exp=1", cl_color_en); end
      n = 0; bv = 0;
      while (cl_color_en && n < 200) begin
         n++;
         if (cl_ver !== mk(0) || cl_rgb !== c || cl_height !== 16'sd0) bv++;
         tick;
      end
      total++; if (n != LAT + 1) begin bad++; $display("FAIL single_en_len got=%0d exp=%0d", n, LAT + 1); end
      total++; if (bv != 0) begin bad++; $display("FAIL single_stable got=%0d bad cycles exp=0", bv); end
      total++; if (busy !== 1'b1 || tri_count !== 16'd0) begin
         bad++; $display("FAIL single_gap got busy=%b cnt=%0d exp busy=1 cnt=0", busy, tri_count); end
      tick; tick;
      total++; if (tri_count !== 16'd1 || busy !== 1'b0) begin
         bad++; $display("FAIL single_done got cnt=%0d busy=%b exp cnt=1 busy=0", tri_count, busy); end
   endtask

   task automatic test_bands;
      int lo, hi, hb;
      logic [15:0] exp_h;
      tri_in = mk(1); rgb_in = '{8'd1, 8'd2, 8'd3};
      total++; if (ready3 !== 1'b1) begin bad++; $display("FAIL bands_ready got=%b exp=1", ready3); end
      tri_valid3 = 1'b1; tick; tri_valid3 = 1'b0;
      for (int p = 0; p < 3; p++) begin
         exp_h = 16'(4 * p);
         lo = 0;
         while (!en3 && lo < 100) begin lo++; tick; end
         total++; if (lo != 2) begin bad++; $display("FAIL bands_gap%0d got=%0d exp=2", p, lo); end
         total++; if (height3 !== exp_h) begin bad++; $display("FAIL bands_h%0d got=%0d exp=%0d", p, height3, exp_h); end
         hi = 0; hb = 0;
         while (en3 && hi < 100) begin
            hi++;
            if (height3 !== exp_h || ver3 !== mk(1) || rgb3 !== rgb_in) hb++;
            tick;
         end
         total++; if (hi != LAT3 + 1 || hb != 0) begin
            bad++; $display("FAIL bands_pass%0d got len=%0d unstable=%0d exp len=%0d unstable=0", p, hi, hb, LAT3 + 1); end
      end
      tick; tick;
      total++; if (cnt3 !== 16'd1 || busy3 !== 1'b0 || fd3 !== 1'b0) begin
         bad++; $display("FAIL bands_done got cnt=%0d busy=%b fd=%b exp 1/0/0", cnt3, busy3, fd3); end
   endtask

   task automatic test_back_to_back;
      int acc, cyc;
      logic prev;
      logic [15:0] base;
      logic [15:0] q[$];
      base = tri_count; acc = 0;
      m_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tri_in = mk(10 + i); tri_valid = 1'b1;
         if (tri_ready) acc++;
         tick;
      end
      total++; if (acc != 5) begin bad++; $display("FAIL b2b_accepted got=%0d exp=5", acc); end
      total++; if (tri_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", tri_ready); end
      tri_in = mk(15);
      tick; tri_valid = 1'b0;
      m_en = 1'b1;
      prev = 1'b0; cyc = 0;
      while (busy && cyc < 3000) begin
         if (cl_color_en && !prev) q.push_back(cl_ver.p.z);
         prev = cl_color_en;
         cyc++; tick;
      end
      total++; if (q.size() != 5) begin bad++; $display("FAIL b2b_launches got=%0d exp=5", q.size()); end
      for (int i = 0; i < 5 && i < q.size(); i++) begin
         total++; if (q[i] !== 16'(110 + i)) begin bad++; $display("FAIL b2b_order%0d got=%0d exp=%0d", i, q[i], 110 + i); end
      end
      total++; if (tri_count !== base + 16'd5) begin
         bad++; $display("FAIL b2b_count got=%0d exp=%0d", tri_count, base + 16'd5); end
   endtask

   task automatic test_flush;
      int pulses;
      logic [15:0] base, tc_at;
      logic busy_at;
      base = tri_count; pulses = 0; tc_at = '0; busy_at = 1'b1;
      tri_in = mk(20); tri_valid = 1'b1; tick;
      tri_in = mk(21); tick;
      tri_valid = 1'b0; flush_req = 1'b1; tick;
      tick; flush_req = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (frame_done) begin
            pulses++;
            if (pulses == 1) begin tc_at = tri_count; busy_at = busy; end
         end
         tick;
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL flush_pulses got=%0d exp=1", pulses); end
      total++; if (tc_at !== base + 16'd2 || busy_at !== 1'b0) begin
         bad++; $display("FAIL flush_when got cnt=%0d busy=%b exp cnt=%0d busy=0", tc_at, busy_at, base + 16'd2); end
      flush_req = 1'b1;
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL flush_idle_early got=%b exp=0", frame_done); end
      tick; flush_req = 1'b0;
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL flush_idle got=%b exp=1", frame_done); end
      tick;
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL flush_idle_once got=%b exp=0", frame_done); end
   endtask

`ifdef SCHED_TIMEOUT_EN
   task automatic test_timeout;
      int n, w;
      logic [15:0] base;
      base = tri_count;
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_initial got=%b exp=0", timeout); end
      ovr = 1'b1; ovr_val = 1'b0;
      tri_in = mk(30); tri_valid = 1'b1; tick;
      tri_in = mk(31); tick; tri_valid = 1'b0;
      w = 0;
      while (!cl_color_en && w < 10) begin w++; tick; end
      n = 0;
      while (cl_color_en && n < 300) begin n++; tick; end
      total++; if (n != 100) begin bad++; $display("FAIL to_len got=%0d exp=100", n); end
      total++; if (timeout !== 1'b1 || tri_count !== base) begin
         bad++; $display("FAIL to_flag got to=%b cnt=%0d exp to=1 cnt=%0d", timeout, tri_count, base); end
      w = 0;
      while (!cl_color_en && w < 10) begin w++; tick; end
      total++; if (cl_color_en !== 1'b1 || cl_ver.p.z !== 16'd131) begin
         bad++; $display("FAIL to_next got en=%b z=%0d exp en=1 z=131", cl_color_en, cl_ver.p.z); end
      w = 0;
      while (busy && w < 300) begin w++; tick; end
      total++; if (busy !== 1'b0 || tri_count !== base) begin
         bad++; $display("FAIL to_end got busy=%b cnt=%0d exp busy=0 cnt=%0d", busy, tri_count, base); end
      ovr = 1'b0;
   endtask
`endif

   task automatic test_stale_reset;
      int w, ens;
      tri_in = mk(40); tri_valid = 1'b1; tick; tri_valid = 1'b0;
      w = 0;
      while (!cl_color_en && w < 10) begin w++; tick; end
      tick; tick;
      ovr = 1'b1; ovr_val = 1'b1;
      n_rst = 1'b0; #1;
      total++; if (cl_color_en !== 1'b0 || busy !== 1'b0 || tri_count !== 16'd0) begin
         bad++; $display("FAIL rst_mid got en=%b busy=%b cnt=%0d exp 0/0/0", cl_color_en, busy, tri_count); end
      tick; tick;
      n_rst = 1'b1;
      ens = 0;
      for (int c = 0; c < 10; c++) begin
         if (cl_color_en || busy) ens++;
         tick;
      end
      total++; if (ens != 0 || tri_count !== 16'd0) begin
         bad++; $display("FAIL rst_stale got active=%0d cnt=%0d exp 0/0", ens, tri_count); end
`ifdef SCHED_TIMEOUT_EN
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
`endif
      ovr = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout sim time exceeded");
      $fatal(1, "global timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_bands();
      test_back_to_back();
      test_flush();
`ifdef SCHED_TIMEOUT_EN
      test_timeout();
`endif
      test_stale_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
